cpu_controller: RTL and testbench

- Eight-phase instruction sequencer for the 8-bit RISC CPU.
- Issues the control strobes consumed by Program_Counter (Load_in, inc_pc, SKZ_cmp), the instruction register, the accumulator and memory.
- It is the initiating end of the Program_Counter control interface: it decides when the PC loads, increments or skips, and when the memory address mux selects PC versus operand.

---
 rtl/cpu_defs.sv | 29 ++
 rtl/cpu_phase_counter.sv | 23 ++
 rtl/cpu_controller.sv | 126 ++++++++++++
 tb/tb_cpu_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared opcode/phase encodings for the 8-bit RISC sequencer.
package cpu_defs;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        PH_INST_ADDR  = 3'd0,
        PH_INST_FETCH = 3'd1,
        PH_INST_LOAD  = 3'd2,
        PH_IDLE       = 3'd3,
        PH_OP_ADDR    = 3'd4,
        PH_OP_FETCH   = 3'd5,
        PH_ALU_OP     = 3'd6,
        PH_STORE      = 3'd7
    } phase_t;

    // Opcodes whose result comes back from memory into the accumulator.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_phase_counter.sv
// Three-bit phase register; steps when advance is high and wraps 7 -> 0.
module cpu_phase_counter
    import cpu_defs::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       advance,
    output logic [2:0] phase
);

    phase_t state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= PH_INST_ADDR;
        end else if (advance) begin
            state <= phase_t'(3'(state + 3'd1));
        end
    end

    assign phase = state;

endmodule

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer driving PC, IR, accumulator and memory strobes.
//   phase | meaning
//   0     | INST_ADDR  : PC onto address bus
//   1     | INST_FETCH : read instruction
//   2     | INST_LOAD  : load IR
//   3     | IDLE       : hold IR load
//   4     | OP_ADDR    : step PC, or halt on HLT
//   5     | OP_FETCH   : read operand for ALU ops
//   6     | ALU_OP     : skip / jump / drive store data
//   7     | STORE      : accumulator load or memory write
module cpu_controller
    import cpu_defs::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               En_cpu_in,
    input  logic [2:0]         Opcode,
    input  logic               zero,
    output logic [2:0]         phase,
    output logic               sel,
    output logic               rd,
    output logic               ld_ir,
    output logic               inc_pc,
    output logic               Load_in,
    output logic               SKZ_cmp,
    output logic               data_e,
    output logic               ld_ac,
    output logic               wr,
    output logic               halt,
    output logic [COUNT_W-1:0] instr_count
);

    phase_t ph;
    logic   halted;
    logic   hlt_now;
    logic   advance;
    logic   alu;

    assign ph      = phase_t'(phase);
    assign hlt_now = (ph == PH_OP_ADDR) && (Opcode == OP_HLT);
    assign advance = En_cpu_in && !halted && !hlt_now;
    assign alu     = is_aluop(Opcode);

    cpu_phase_counter u_phase (
        .clock   (clock),
        .reset   (reset),
        .advance (advance),
        .phase   (phase)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            if (En_cpu_in && !halted && hlt_now) begin
                halted <= 1'b1;
            end
            if (advance && (ph == PH_STORE)) begin
                instr_count <= instr_count + COUNT_W'(1);
            end
        end
    end

    always_comb begin
        sel     = 1'b0;
        rd      = 1'b0;
        ld_ir   = 1'b0;
        inc_pc  = 1'b0;
        Load_in = 1'b0;
        SKZ_cmp = 1'b0;
        data_e  = 1'b0;
        ld_ac   = 1'b0;
        wr      = 1'b0;
        halt    = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (ph)
                PH_INST_ADDR: sel = 1'b1;
                PH_INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                PH_INST_LOAD, PH_IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                PH_OP_ADDR: begin
                    halt   = (Opcode == OP_HLT);
                    inc_pc = (Opcode != OP_HLT);
                end
                PH_OP_FETCH: rd = alu;
                PH_ALU_OP: begin
                    rd      = alu;
                    SKZ_cmp = (Opcode == OP_SKZ) && zero;
                    inc_pc  = (Opcode == OP_SKZ) && zero;
                    Load_in = (Opcode == OP_JMP);
                    data_e  = (Opcode == OP_STO);
                end
                PH_STORE: begin
                    rd      = alu;
                    ld_ac   = alu;
                    Load_in = (Opcode == OP_JMP);
                    data_e  = (Opcode == OP_STO);
                    wr      = (Opcode == OP_STO);
                end
                default: sel = 1'b0;
            endcase
            // Stalled: kill strobes, keep address mux and data drive steady.
            if (!En_cpu_in) begin
                rd      = 1'b0;
                ld_ir   = 1'b0;
                inc_pc  = 1'b0;
                Load_in = 1'b0;
                SKZ_cmp = 1'b0;
                ld_ac   = 1'b0;
                wr      = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Scoreboard bench for cpu_controller: expected output vectors are queued per cycle and popped at the sample point.
module tb_cpu_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       En_cpu_in;
    logic [2:0] Opcode;
    logic       zero;
    logic [2:0] phase;
    logic       sel, rd, ld_ir, inc_pc, Load_in, SKZ_cmp, data_e, ld_ac, wr, halt;
    logic [7:0] instr_count;

    cpu_controller #(.COUNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .En_cpu_in   (En_cpu_in),
        .Opcode      (Opcode),
        .zero        (zero),
        .phase       (phase),
        .sel         (sel),
        .rd          (rd),
        .ld_ir       (ld_ir),
        .inc_pc      (inc_pc),
        .Load_in     (Load_in),
        .SKZ_cmp     (SKZ_cmp),
        .data_e      (data_e),
        .ld_ac       (ld_ac),
        .wr          (wr),
        .halt        (halt),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [20:0] v;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [2:0]  m_ph;
    logic [7:0]  m_cnt;
    logic        m_halted;
    logic [20:0] got;

    assign got = {phase, sel, rd, ld_ir, inc_pc, Load_in, SKZ_cmp, data_e, ld_ac, wr, halt, instr_count};

    function automatic logic [20:0] exp_vec(input logic [2:0] ph, input logic [2:0] op, input logic z,
                                            input logic en, input logic hl, input logic [7:0] cnt);
        logic e_sel, e_rd, e_ir, e_inc, e_ld, e_skz, e_de, e_ac, e_wr, e_h, alu;
        alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        {e_sel, e_rd, e_ir, e_inc, e_ld, e_skz, e_de, e_ac, e_wr, e_h} = '0;
        if (hl) begin
            e_h = 1'b1;
        end else begin
            case (ph)
                3'd0: e_sel = 1'b1;
                3'd1: {e_sel, e_rd} = 2'b11;
                3'd2, 3'd3: {e_sel, e_rd, e_ir} = 3'b111;
                3'd4: begin e_h = (op == 3'd0); e_inc = (op != 3'd0); end
                3'd5: e_rd = alu;
                3'd6: begin
                    e_rd = alu; e_skz = (op == 3'd1) && z; e_inc = e_skz;
                    e_ld = (op == 3'd7); e_de = (op == 3'd6);
                end
                default: begin
                    e_rd = alu; e_ac = alu; e_ld = (op == 3'd7);
                    e_de = (op == 3'd6); e_wr = (op == 3'd6);
                end
            endcase
            if (!en) {e_rd, e_ir, e_inc, e_ld, e_skz, e_ac, e_wr} = '0;
        end
        return {ph, e_sel, e_rd, e_ir, e_inc, e_ld, e_skz, e_de, e_ac, e_wr, e_h, cnt};
    endfunction

    task automatic drive(input logic [2:0] op, input logic z, input logic en, input string name);
        exp_t x;
        Opcode    = op;
        zero      = z;
        En_cpu_in = en;
        x.v       = exp_vec(m_ph, op, z, en, m_halted, m_cnt);
        x.name    = name;
        sb.push_back(x);
    endtask

    task automatic tick(input logic [2:0] op, input logic en);
        @(posedge clock);
        if (en && !m_halted) begin
            if (m_ph == 3'd4 && op == 3'd0) m_halted = 1'b1;
            else begin
                if (m_ph == 3'd7) m_cnt = m_cnt + 8'd1;
                m_ph = m_ph + 3'd1;
            end
        end
        #1;
    endtask

    task automatic model_reset();
        m_ph = 3'd0; m_cnt = 8'd0; m_halted = 1'b0;
    endtask

    task automatic release_reset();
        En_cpu_in = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; En_cpu_in = 1'b0; Opcode = 3'd2; zero = 1'b0;
        model_reset();
        #3;
        drive(3'd2, 1'b0, 1'b0, "reset_init");
        e = sb.pop_front(); n_tests++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        release_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'd2, 1'b0, 1'b1, "reset_run");
            @(negedge clock);
            e = sb.pop_front(); n_tests++;
            if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
            tick(3'd2, 1'b1);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        drive(3'd2, 1'b0, 1'b1, "reset_mid_ph5");
        e = sb.pop_front(); n_tests++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        release_reset();
    endtask

    task automatic test_instr(input logic [2:0] op, input logic z, input string name);
        for (int i = 0; i < 8; i++) begin
            drive(op, z, 1'b1, name);
            @(negedge clock);
            e = sb.pop_front(); n_tests++;
            if (got !== e.v) begin n_fail++; $display("FAIL %s ph%0d: got %h expected %h", e.name, i, got, e.v); end
            tick(op, 1'b1);
        end
    endtask

    task automatic test_opcode_ignore();
        logic [2:0] op;
        for (int i = 0; i < 8; i++) begin
            op = (i < 4) ? 3'($urandom_range(0, 7)) : 3'd2;
            drive(op, 1'($urandom_range(0, 1)), 1'b1, "opcode_ignore");
            @(negedge clock);
            e = sb.pop_front(); n_tests++;
            if (got !== e.v) begin n_fail++; $display("FAIL %s ph%0d: got %h expected %h", e.name, i, got, e.v); end
            tick(op, 1'b1);
        end
    endtask

    task automatic test_stall();
        logic en;
        for (int i = 0; i < 11; i++) begin
            en = !(i >= 2 && i < 5);
            drive(3'd3, 1'b0, en, "stall");
            @(negedge clock);
            e = sb.pop_front(); n_tests++;
            if (got !== e.v) begin n_fail++; $display("FAIL %s cyc%0d: got %h expected %h", e.name, i, got, e.v); end
            tick(3'd3, en);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        logic       z;
        for (int k = 0; k < 6; k++) begin
            op = 3'($urandom_range(1, 7));
            z  = 1'($urandom_range(0, 1));
            for (int i = 0; i < 8; i++) begin
                drive(op, z, 1'b1, "back_to_back");
                @(negedge clock);
                e = sb.pop_front(); n_tests++;
                if (got !== e.v) begin n_fail++; $display("FAIL %s op%0d ph%0d: got %h expected %h", e.name, op, i, got, e.v); end
                tick(op, 1'b1);
            end
        end
    endtask

    task automatic test_count_wrap();
        int n;
        n = 256 - int'(m_cnt) + 1;
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 8; i++) begin
                drive(3'd4, 1'b0, 1'b1, "count_wrap");
                @(negedge clock);
                e = sb.pop_front(); n_tests++;
                if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
                tick(3'd4, 1'b1);
            end
        end
    endtask

    task automatic test_hlt();
        logic [2:0] op;
        for (int i = 0; i < 25; i++) begin
            op = (i < 5) ? 3'd0 : 3'($urandom_range(0, 7));
            drive(op, 1'($urandom_range(0, 1)), 1'b1, "hlt");
            @(negedge clock);
            e = sb.pop_front(); n_tests++;
            if (got !== e.v) begin n_fail++; $display("FAIL %s cyc%0d: got %h expected %h", e.name, i, got, e.v); end
            tick(op, 1'b1);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        drive(3'd0, 1'b0, 1'b1, "hlt_reset_clear");
        e = sb.pop_front(); n_tests++;
        if (got !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.name, got, e.v); end
        release_reset();
        test_instr(3'd2, 1'b0, "after_hlt");
    endtask

    initial begin
        test_reset();
        test_instr(3'd7, 1'b0, "jmp");
        test_instr(3'd1, 1'b1, "skz_z1");
        test_instr(3'd1, 1'b0, "skz_z0");
        test_instr(3'd6, 1'b1, "sto");
        test_instr(3'd5, 1'b0, "lda");
        test_opcode_ignore();
        test_stall();
        test_back_to_back();
        test_count_wrap();
        test_hlt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
